// File: rtl/mem_arbiter_if.sv
// Two-requester data-memory bus: CPU MEM stage (m0), loader/DMA (m1), and the memory port.
// The arbiter connects through 'slave'. Requesters and the memory model connect through 'master'.
interface mem_arbiter_if;
  logic        m0_req,   m1_req;
  logic        m0_wr,    m1_wr;
  logic [31:0] m0_addr,  m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt,   m1_gnt;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rvalid, m1_rvalid;
  logic        mem_rd,   mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
    output m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
    input  m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter. m0 has fixed priority, and m1 is forced through after MAX_WAIT denied cycles.
// Grant in cycle N, memory access in N+1, read data valid in N+2. One access per cycle.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] MAX_WAIT_C = 3'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  wait_cnt;
  logic        lat_wr;
  logic [31:0] lat_addr, lat_wdata;
  logic        gnt0, gnt1;
  logic        m1_pri;
  logic        rd_rd, rd_wr;
  logic [31:0] rd_addr, rd_wdata;
  logic        rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;

  assign m1_pri = bus.m1_req && (wait_cnt >= MAX_WAIT_C);

  always_comb begin
    state_d  = IDLE;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rd_rd    = 1'b0;
    rd_wr    = 1'b0;
    rd_addr  = '0;
    rd_wdata = '0;
    if (!reset) begin
      if (m1_pri)          gnt1 = 1'b1;
      else if (bus.m0_req) gnt0 = 1'b1;
      else if (bus.m1_req) gnt1 = 1'b1;

      if (gnt0)      state_d = ACC0;
      else if (gnt1) state_d = ACC1;

      // The state names the owner of this cycle's memory access, and the latch holds its command.
      if (state_q != IDLE) begin
        rd_rd    = ~lat_wr;
        rd_wr    = lat_wr;
        rd_addr  = lat_addr;
        rd_wdata = lat_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (gnt0) begin
      lat_wr    <= bus.m0_wr;
      lat_addr  <= bus.m0_addr;
      lat_wdata <= bus.m0_wdata;
    end else if (gnt1) begin
      lat_wr    <= bus.m1_wr;
      lat_addr  <= bus.m1_addr;
      lat_wdata <= bus.m1_wdata;
    end
  end

  // Counts consecutive denied cycles of m1. A withdrawn request or a grant starts it over.
  always_ff @(posedge clk) begin
    if (reset || !bus.m1_req || gnt1) wait_cnt <= '0;
    else if (wait_cnt != 3'd7)        wait_cnt <= wait_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= (state_q == ACC0) && !lat_wr;
      rvalid1 <= (state_q == ACC1) && !lat_wr;
      if ((state_q == ACC0) && !lat_wr) rdata0 <= bus.mem_rdata;
      if ((state_q == ACC1) && !lat_wr) rdata1 <= bus.mem_rdata;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.mem_rd    = rd_rd;
  assign bus.mem_wr    = rd_wr;
  assign bus.mem_addr  = rd_addr;
  assign bus.mem_wdata = rd_wdata;
  assign bus.m0_rvalid = rvalid0;
  assign bus.m1_rvalid = rvalid1;
  assign bus.m0_rdata  = rdata0;
  assign bus.m1_rdata  = rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Directed requester stimulus and a word memory model.
// Expected accesses and read data are queued when driven, then retired by a bus monitor.
module tb_mem_arbiter;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  acc_t        acc_q[$];
  logic [31:0] rd0_q[$];
  logic [31:0] rd1_q[$];

  logic [31:0] mem_q   [64];
  bit          mem_vld [64];

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hC0DE_0000);
  endfunction

  always_comb begin
    bus.mem_rdata = mem_vld[bus.mem_addr[7:2]] ? mem_q[bus.mem_addr[7:2]]
                                               : mem_default(bus.mem_addr);
  end

  always @(posedge clk) begin
    if (bus.mem_wr) begin
      mem_q[bus.mem_addr[7:2]]   <= bus.mem_wdata;
      mem_vld[bus.mem_addr[7:2]] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Bus monitor: retires queued expectations as accesses and read data appear.
  always @(negedge clk) begin
    acc_t e;
    chk("gnt_excl", {31'd0, bus.m0_gnt & bus.m1_gnt}, 32'd0);
    if (bus.mem_rd || bus.mem_wr) begin
      if (acc_q.size() == 0) chk("unexpected_access", bus.mem_addr, 32'hFFFF_FFFF);
      else begin
        e = acc_q.pop_front();
        chk("acc_wr", {31'd0, bus.mem_wr}, {31'd0, e.wr});
        chk("acc_rd", {31'd0, bus.mem_rd}, {31'd0, ~e.wr});
        chk("acc_addr", bus.mem_addr, e.addr);
        if (e.wr) chk("acc_wdata", bus.mem_wdata, e.wdata);
      end
    end
    if (bus.m0_rvalid) begin
      if (rd0_q.size() == 0) chk("unexpected_rvalid0", bus.m0_rdata, 32'hFFFF_FFFF);
      else chk("rdata0", bus.m0_rdata, rd0_q.pop_front());
    end
    if (bus.m1_rvalid) begin
      if (rd1_q.size() == 0) chk("unexpected_rvalid1", bus.m1_rdata, 32'hFFFF_FFFF);
      else chk("rdata1", bus.m1_rdata, rd1_q.pop_front());
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive0(input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.m0_req = req; bus.m0_wr = wr; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic drive1(input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.m1_req = req; bus.m1_wr = wr; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  task automatic expect_rd(input bit port, input logic [31:0] a, input logic [31:0] data);
    acc_q.push_back('{wr: 1'b0, addr: a, wdata: 32'd0});
    if (port) rd1_q.push_back(data);
    else      rd0_q.push_back(data);
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    chk({tag, "_g0"}, {31'd0, bus.m0_gnt}, {31'd0, g0});
    chk({tag, "_g1"}, {31'd0, bus.m1_gnt}, {31'd0, g1});
  endtask

  task automatic drain();
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    drive1(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) next_cyc();
  endtask

  initial begin
    bit exp_m1;
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    drive1(1'b0, 1'b0, 32'd0, 32'd0);

    // Reset values
    repeat (2) next_cyc();
    drive0(1'b1, 1'b0, 32'h10, 32'd0);
    smp();
    chk_gnt("rst", 1'b0, 1'b0);
    chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_rvalid", {30'd0, bus.m0_rvalid, bus.m1_rvalid}, 32'd0);
    chk("rst_rdata0", bus.m0_rdata, 32'd0);
    chk("rst_rdata1", bus.m1_rdata, 32'd0);

    // Single read of 0x10, granted in the first cycle out of reset
    next_cyc();
    reset = 1'b0;
    expect_rd(1'b0, 32'h10, 32'hDEADBEEF);
    smp();
    chk_gnt("rd_n", 1'b1, 1'b0);
    next_cyc();
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    smp();
    chk("rd_n1_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
    chk("rd_n1_addr", bus.mem_addr, 32'h10);
    chk("rd_n1_rvalid", {31'd0, bus.m0_rvalid}, 32'd0);
    next_cyc();
    smp();
    chk("rd_n2_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
    chk("rd_n2_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("rd_n2_idle", {31'd0, bus.mem_rd}, 32'd0);
    next_cyc();
    smp();
    chk("rd_n3_rvalid", {31'd0, bus.m0_rvalid}, 32'd0);
    chk("rd_n3_hold", bus.m0_rdata, 32'hDEADBEEF);
    drain();

    // m1 write
    drive1(1'b1, 1'b1, 32'h20, 32'h12345678);
    acc_q.push_back('{wr: 1'b1, addr: 32'h20, wdata: 32'h12345678});
    smp();
    chk_gnt("wr_n", 1'b0, 1'b1);
    next_cyc();
    drive1(1'b0, 1'b0, 32'd0, 32'd0);
    smp();
    chk("wr_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
    chk("wr_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("wr_addr", bus.mem_addr, 32'h20);
    chk("wr_wdata", bus.mem_wdata, 32'h12345678);
    next_cyc();
    smp();
    chk("wr_no_rvalid", {31'd0, bus.m1_rvalid}, 32'd0);
    drain();

    // Contention for one cycle: m0 first, m1 next, with back-to-back accesses
    drive0(1'b1, 1'b0, 32'h30, 32'd0);
    drive1(1'b1, 1'b0, 32'h40, 32'd0);
    expect_rd(1'b0, 32'h30, mem_default(32'h30));
    expect_rd(1'b1, 32'h40, mem_default(32'h40));
    smp();
    chk_gnt("cont_n", 1'b1, 1'b0);
    next_cyc();
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    smp();
    chk_gnt("cont_n1", 1'b0, 1'b1);
    chk("cont_n1_addr", bus.mem_addr, 32'h30);
    next_cyc();
    drive1(1'b0, 1'b0, 32'd0, 32'd0);
    smp();
    chk("cont_n2_rd", {31'd0, bus.mem_rd}, 32'd1);
    chk("cont_n2_addr", bus.mem_addr, 32'h40);
    drain();

    // Starvation: both held high for 10 cycles
    for (int i = 0; i < 10; i++) begin
      exp_m1 = (i == 4) || (i == 9);
      drive0(1'b1, 1'b0, 32'h50, 32'd0);
      drive1(1'b1, 1'b0, 32'h60, 32'd0);
      if (exp_m1) expect_rd(1'b1, 32'h60, mem_default(32'h60));
      else        expect_rd(1'b0, 32'h50, mem_default(32'h50));
      smp();
      chk_gnt($sformatf("starve_%0d", i), !exp_m1, exp_m1);
      next_cyc();
    end
    drain();

    // Withdraw after two denied cycles; the next m1 request waits a full MAX_WAIT again
    for (int i = 0; i < 9; i++) begin
      exp_m1 = (i == 8);
      drive0(1'b1, 1'b0, 32'h70, 32'd0);
      drive1((i < 2) || (i >= 4), 1'b0, 32'h74, 32'd0);
      if (exp_m1) expect_rd(1'b1, 32'h74, mem_default(32'h74));
      else        expect_rd(1'b0, 32'h70, mem_default(32'h70));
      smp();
      chk_gnt($sformatf("withdraw_%0d", i), !exp_m1, exp_m1);
      next_cyc();
    end
    drain();

    // Reset in the cycle after a write is granted
    drive0(1'b1, 1'b1, 32'h24, 32'hAAAA5555);
    smp();
    chk_gnt("rstmid_n", 1'b1, 1'b0);
    next_cyc();
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    drive1(1'b1, 1'b0, 32'h44, 32'd0);
    reset = 1'b1;
    smp();
    chk("rstmid_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rstmid_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk_gnt("rstmid_gnt", 1'b0, 1'b0);
    next_cyc();
    reset = 1'b0;
    drive1(1'b0, 1'b0, 32'd0, 32'd0);
    drive0(1'b1, 1'b0, 32'h24, 32'd0);
    expect_rd(1'b0, 32'h24, mem_default(32'h24));
    smp();
    chk("rstmid_rvalid", {30'd0, bus.m0_rvalid, bus.m1_rvalid}, 32'd0);
    chk("rstmid_rdata0", bus.m0_rdata, 32'd0);
    chk("rstmid_mem_idle", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
    chk_gnt("post_rst", 1'b1, 1'b0);
    next_cyc();
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    drive1(1'b1, 1'b0, 32'h20, 32'd0);
    expect_rd(1'b1, 32'h20, 32'h12345678);
    smp();
    chk_gnt("readback", 1'b0, 1'b1);
    next_cyc();
    drain();
    repeat (2) next_cyc();

    chk("acc_q_left", acc_q.size(), 32'd0);
    chk("rd0_q_left", rd0_q.size(), 32'd0);
    chk("rd1_q_left", rd1_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, meaning consecutive denied cycles after which requester 1 wins arbitration (legal 1..7).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports m0_req, m1_req  input  1  access request from CPU MEM stage (m0) and loader/DMA (m1).
REQ-005 SHALL have ports m0_wr, m1_wr  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports m0_addr, m1_addr  input  32  byte address.
REQ-007 SHALL have ports m0_wdata, m1_wdata  input  32  write data.
REQ-008 SHALL have ports m0_gnt, m1_gnt  output  1  request accepted this cycle.
REQ-009 SHALL have ports m0_rdata, m1_rdata  output  32  read data, meaningful only while the matching rvalid is high.
REQ-010 SHALL have ports m0_rvalid, m1_rvalid  output  1  one-cycle read-data-valid pulse.
REQ-011 SHALL have ports mem_rd, mem_wr  output  1  data-memory read/write strobes.
REQ-012 SHALL have ports mem_addr, mem_wdata  output  32  data-memory address and write data.
REQ-013 SHALL have port mem_rdata  input  32  data-memory read data, valid in the same cycle as mem_rd.

Function
REQ-014 SHALL use a 3-state FSM: IDLE (no access), ACC0 (access for m0), ACC1 (access for m1); the state is the owner of the current memory cycle.
REQ-015 SHALL arbitrate every cycle in every state; winner accepted via combinational gnt in that cycle, and next state becomes ACC0/ACC1 for the winner, or IDLE if no request.
REQ-016 SHALL assert at most one of m0_gnt/m1_gnt in any cycle; gnt only when the matching req is high.
REQ-017 SHALL give m0 fixed priority, except m1 SHALL win whenever wait_cnt >= MAX_WAIT and m1_req is high.
REQ-018 SHALL keep a 3-bit wait_cnt: +1 each cycle m1_req=1 and m1_gnt=0 (saturating at 7); cleared on m1_gnt or when m1_req=0.
REQ-019 SHALL latch the winner's wr, addr, wdata on acceptance; during ACCx drive mem_addr/mem_wdata from the latch, mem_wr=latched wr, mem_rd=~latched wr.
REQ-020 SHALL in IDLE drive mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-021 SHALL on a read in ACCx register mem_rdata into mx_rdata and pulse mx_rvalid high for exactly the following cycle; writes produce no rvalid.
REQ-022 SHALL give read latency: gnt at cycle N, memory access at N+1, rvalid at N+2; throughput one access per cycle, no bubble between back-to-back grants.
REQ-023 SHALL hold mx_rdata unchanged between rvalid pulses.
REQ-024 SHALL treat a req dropped before grant as withdrawn; no access, no state change for it.
REQ-025 SHALL expect requesters to present a new or no request in the cycle after gnt; req still high then is a new request.
REQ-026 SHALL with both req high and wait_cnt < MAX_WAIT grant m0; m1 waits.

Reset
REQ-027 SHALL on reset=1 at a clock edge set state=IDLE, wait_cnt=0, latches=0, m0_rdata=m1_rdata=0, m0_rvalid=m1_rvalid=0.
REQ-028 SHALL while reset=1 force m0_gnt=m1_gnt=0, mem_rd=mem_wr=0.
REQ-029 SHALL drop any accepted-but-unserved or in-flight access on reset; no memory write and no rvalid occur for it.
REQ-030 SHALL grant normally in the first cycle after reset deasserts.

Verification
REQ-031 Single read: m0_req=1, wr=0, addr=0x10 at N, mem_rdata=0xDEADBEEF -> m0_gnt at N, mem_rd=1 addr=0x10 at N+1, m0_rvalid=1 rdata=0xDEADBEEF at N+2.
REQ-032 Contention: both req high for 1 cycle -> m0_gnt only; m1 granted next cycle (m0 idle); accesses in ACC0 then ACC1 with no gap.
REQ-033 Starvation: m0_req and m1_req held high, MAX_WAIT=4 -> m0 granted 4 cycles, m1_gnt on 5th cycle, wait_cnt=0 after, then m0 resumes.
REQ-034 Write: m1 write addr=0x20 wdata=0x12345678 -> mem_wr=1 with those values one cycle after m1_gnt; no m1_rvalid.
REQ-035 Reset mid-operation: reset=1 in cycle after m0_gnt of a write -> mem_wr stays 0, rvalid stays 0, all outputs at reset values.
REQ-036 Withdraw: m1_req high 2 cycles under m0 priority then low -> no m1_gnt, wait_cnt returns to 0.
